// File: rtl/bus_master_port_if.sv
// Core-side handshake and system-bus control signals of bus_master_port.
// The tri-state data_bus is a plain inout port of the master, not part of this interface.
interface bus_master_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  modport master (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, fc_bus,
    output req_ready, resp_valid, resp_rdata, resp_err, addr_bus, rd_bus, wr_bus, data_mask_bus
  );

  modport slave (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, fc_bus,
    input  req_ready, resp_valid, resp_rdata, resp_err, addr_bus, rd_bus, wr_bus, data_mask_bus
  );
endinterface

// File: rtl/bus_master_port.sv
// CPU-side master: one load/store at a time, one bus cycle, extended read data plus error flag.
// Optional macro BUS_TIMEOUT_EN aborts a bus cycle after TIMEOUT_CYCLES cycles without fc_bus.
module bus_master_port #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  bus_master_port_if.master bus,
  inout  wire  [31:0]       data_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic        drive_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] addr_bus_q;
  logic        rd_bus_q;
  logic        wr_bus_q;
  logic [3:0]  mask_q;

  logic        illegal_d;
  logic [3:0]  mask_d;
  logic        fc_done_d;
  logic        timeout_d;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lsb[0];
      2'd2:    bad = |lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic uns);
    logic [31:0] res;
    case (size)
      2'd0:    res = {{24{~uns & raw[7]}}, raw[7:0]};
      2'd1:    res = {{16{~uns & raw[15]}}, raw[15:0]};
      2'd2:    res = raw;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Only a solid 1 on fc_bus completes a cycle; a floating line never does.
  assign fc_done_d = (bus.fc_bus === 1'b1);
  assign illegal_d = req_illegal(bus.req_size, bus.req_addr[1:0]);
  assign mask_d    = size_mask(bus.req_size);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout_d = (cnt_q == CNT_LAST);

  // Counts BUS cycles that ended without completion; cleared whenever a new bus cycle starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (state_q != S_BUS) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (!fc_done_d && !timeout_d) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_d = 1'b0;

  // The bus cycle ends only on fc_bus here; the parameter just keeps one port list for both builds.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Request FSM; every bus and response output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      drive_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      addr_bus_q   <= 32'h0000_0000;
      rd_bus_q     <= 1'b0;
      wr_bus_q     <= 1'b0;
      mask_q       <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q        <= bus.req_wr;
            size_q      <= bus.req_size;
            unsigned_q  <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (illegal_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else begin
              state_q    <= S_BUS;
              addr_bus_q <= bus.req_addr;
              rd_bus_q   <= ~bus.req_wr;
              wr_bus_q   <= bus.req_wr;
              mask_q     <= mask_d;
              drive_q    <= bus.req_wr;
            end
          end
        end
        S_BUS: begin
          if (fc_done_d || timeout_d) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~fc_done_d;
            resp_rdata_q <= (wr_q || !fc_done_d) ? 32'h0000_0000
                                                 : load_extend(data_bus, size_q, unsigned_q);
            addr_bus_q   <= 32'h0000_0000;
            rd_bus_q     <= 1'b0;
            wr_bus_q     <= 1'b0;
            mask_q       <= 4'b0000;
            drive_q      <= 1'b0;
          end
        end
        S_RESP: begin
          // One strobe-free cycle lets the slave drop its stale completion flag.
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
          addr_bus_q   <= 32'h0000_0000;
          rd_bus_q     <= 1'b0;
          wr_bus_q     <= 1'b0;
          mask_q       <= 4'b0000;
          drive_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.addr_bus      = addr_bus_q;
  assign bus.rd_bus        = rd_bus_q;
  assign bus.wr_bus        = wr_bus_q;
  assign bus.data_mask_bus = mask_q;
  assign data_bus          = drive_q ? wdata_q : {32{1'bz}};

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: vector table, hand-written reset/timeout sequences, random traffic.
module tb_bus_master_port;
  logic       clk = 1'b0;
  logic       rst;
  wire [31:0] data_bus;

  bus_master_port_if bif();

  bus_master_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  // Slave model: asserts fc after (waits + 2) strobe cycles, flag lingers one cycle after strobe drops.
  int          slv_waits;
  int          slv_hi;
  logic [31:0] slv_rdata;
  logic        slv_fc;
  logic        slv_drive;
  logic        slv_prev_act;

  assign bif.fc_bus = slv_fc;
  assign data_bus   = slv_drive ? slv_rdata : {32{1'bz}};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bif.rd_bus || bif.wr_bus) begin
      slv_hi       = slv_hi + 1;
      slv_fc       = (slv_hi >= slv_waits + 2);
      slv_drive    = bif.rd_bus && slv_fc;
      slv_prev_act = 1'b1;
    end else begin
      slv_hi       = 0;
      slv_fc       = slv_fc && slv_prev_act;
      slv_drive    = 1'b0;
      slv_prev_act = 1'b0;
    end
  endtask

  // Reference model from the access rules: alignment by byte count, extension by arithmetic.
  function automatic void model(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] rdata,
                                output logic err, output logic [31:0] res);
    longint unsigned nbytes, full, v;
    err = 1'b0;
    res = 32'h0;
    if (size == 2'd3) begin
      err = 1'b1;
    end else begin
      nbytes = longint'(1) << size;
      err = (longint'(addr) % nbytes) != 0;
      if (!err && !wr) begin
        full = longint'(1) << (8 * nbytes);
        v = longint'(rdata) % full;
        if (!uns && nbytes < 4 && v >= full / 2) v = v - full;
        res = v[31:0];
      end
    end
  endfunction

  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bif.req_valid    = 1'b1;
    bif.req_wr       = wr;
    bif.req_size     = size;
    bif.req_unsigned = uns;
    bif.req_addr     = addr;
    bif.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic exp_err, input logic [31:0] exp_rdata);
    int          lat, hi, exp_lat, exp_hi;
    logic        bus_ok, released, got_err;
    logic [31:0] got_rdata;
    logic [3:0]  exp_mask;
    exp_lat  = exp_err ? 1 : 3 + waits;
    exp_hi   = exp_err ? 0 : 2 + waits;
    exp_mask = (size == 2'd3) ? 4'b0000 : 4'((32'd1 << (32'd1 << size)) - 32'd1);
    slv_waits = waits;
    slv_rdata = rdata;
    step();
    check({tag, "_ready"}, 32'(bif.req_ready), 32'd1);
    issue(wr, size, uns, addr, wdata);
    lat = 0; hi = 0; bus_ok = 1'b1; released = 1'b1; got_err = 1'b0; got_rdata = 32'h0;
    for (int k = 1; k <= 64 && lat == 0; k++) begin
      step();
      if (bif.req_ready) bus_ok = 1'b0;
      if (bif.rd_bus || bif.wr_bus) begin
        hi++;
        if (bif.rd_bus != !wr || bif.wr_bus != wr || bif.addr_bus != addr ||
            bif.data_mask_bus != exp_mask) bus_ok = 1'b0;
        if (wr && data_bus !== wdata) bus_ok = 1'b0;
      end else if (bif.addr_bus != 32'h0 || bif.data_mask_bus != 4'h0) begin
        bus_ok = 1'b0;
      end
      if (bif.resp_valid) begin
        lat       = k;
        got_err   = bif.resp_err;
        got_rdata = bif.resp_rdata;
        if (wr && data_bus === wdata) released = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_strobe_cycles"}, 32'(hi), 32'(exp_hi));
    check({tag, "_bus_ctrl"}, 32'(bus_ok), 32'd1);
    check({tag, "_data_release"}, 32'(released), 32'd1);
    step();
    check({tag, "_resp_pulse"}, {30'd0, bif.resp_valid, bif.req_ready}, 32'd1);
  endtask

  initial begin
    int          hi, lat, got;
    logic        m_err, got_err;
    logic [31:0] m_rdata, got_rdata;
    logic        r_wr, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;

    vecs[0]  = '{"lw_0x10",     1'b0, 2'd2, 1'b0, 32'h10,  32'h0,         32'h8765_4321, 0, 1'b0, 32'h8765_4321};
    vecs[1]  = '{"lb_signed",   1'b0, 2'd0, 1'b0, 32'h13,  32'h0,         32'h0000_0080, 0, 1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{"lb_unsigned", 1'b0, 2'd0, 1'b1, 32'h13,  32'h0,         32'h0000_0080, 0, 1'b0, 32'h0000_0080};
    vecs[3]  = '{"sh_0x22",     1'b1, 2'd1, 1'b0, 32'h22,  32'h0000_BEEF, 32'h0,         2, 1'b0, 32'h0};
    vecs[4]  = '{"lw_misalign", 1'b0, 2'd2, 1'b0, 32'h2,   32'h0,         32'hFFFF_FFFF, 0, 1'b1, 32'h0};
    vecs[5]  = '{"size3",       1'b0, 2'd3, 1'b0, 32'h100, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 32'h0};
    vecs[6]  = '{"lh_signed",   1'b0, 2'd1, 1'b0, 32'h46,  32'h0,         32'h1234_F00D, 1, 1'b0, 32'hFFFF_F00D};
    vecs[7]  = '{"lh_unsigned", 1'b0, 2'd1, 1'b1, 32'h46,  32'h0,         32'hABCD_8001, 3, 1'b0, 32'h0000_8001};
    vecs[8]  = '{"sb_odd",      1'b1, 2'd0, 1'b0, 32'h7,   32'h0000_00A5, 32'h0,         0, 1'b0, 32'h0};
    vecs[9]  = '{"sw_misalign", 1'b1, 2'd2, 1'b0, 32'h5,   32'h1111_1111, 32'h0,         0, 1'b1, 32'h0};
    vecs[10] = '{"lb_pos",      1'b0, 2'd0, 1'b0, 32'h81,  32'h0,         32'hFFFF_FF7F, 2, 1'b0, 32'h0000_007F};
    vecs[11] = '{"sw_waits",    1'b1, 2'd2, 1'b0, 32'h0,   32'hDEAD_BEEF, 32'h0,         3, 1'b0, 32'h0};

    rst = 1'b1;
    bif.req_valid = 1'b0; bif.req_wr = 1'b0; bif.req_size = 2'd0; bif.req_unsigned = 1'b0;
    bif.req_addr = 32'h0; bif.req_wdata = 32'h0;
    slv_waits = 0; slv_hi = 0; slv_rdata = 32'h0; slv_fc = 1'b0; slv_drive = 1'b0; slv_prev_act = 1'b0;
    repeat (3) step();
    check("reset_ready", 32'(bif.req_ready), 32'd1);
    check("reset_outputs", {bif.resp_valid, bif.resp_err, bif.rd_bus, bif.wr_bus, bif.data_mask_bus}, 32'd0);
    check("reset_addr_rdata", bif.addr_bus | bif.resp_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].tag, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].waits, vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Reset during the third wait cycle of a store: no response, bus released immediately.
    slv_waits = 10;
    step();
    issue(1'b1, 2'd2, 1'b0, 32'h80, 32'h1122_3344);
    repeat (5) step();
    check("rst_pre_wr", 32'(bif.wr_bus), 32'd1);
    rst = 1'b1;
    step();
    check("rst_wr_low", {30'd0, bif.wr_bus, bif.rd_bus}, 32'd0);
    check("rst_data_rel", 32'(data_bus === 32'h1122_3344), 32'd0);
    check("rst_ready", 32'(bif.req_ready), 32'd1);
    check("rst_no_resp", {30'd0, bif.resp_valid, bif.resp_err}, 32'd0);
    rst = 1'b0;
    got = 0;
    repeat (6) begin
      step();
      if (bif.resp_valid) got = 1;
    end
    check("rst_no_late_resp", 32'(got), 32'd0);

    // Unresponsive slave: timeout abort when enabled, otherwise an indefinite wait.
    slv_waits = 1000000;
    step();
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    hi = 0; lat = 0; got_err = 1'b0; got_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bif.rd_bus) hi++;
      if (bif.resp_valid && lat == 0) begin
        lat = k; got_err = bif.resp_err; got_rdata = bif.resp_rdata;
      end
    end
`ifdef BUS_TIMEOUT_EN
    check("tmo_strobe_cycles", 32'(hi), 32'd8);
    check("tmo_latency", 32'(lat), 32'd9);
    check("tmo_err", 32'(got_err), 32'd1);
    check("tmo_rdata", got_rdata, 32'd0);
`else
    check("stall_strobe_cycles", 32'(hi), 32'd20);
    check("stall_no_resp", 32'(lat), 32'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      if ($urandom_range(0, 2) != 0) r_addr[1:0] = 2'b00;
      r_wdata = $urandom | 32'd1;
      r_rdata = $urandom;
      model(r_wr, r_size, r_uns, r_addr, r_rdata, m_err, m_rdata);
      run_txn("rnd", r_wr, r_size, r_uns, r_addr, r_wdata, r_rdata,
              int'($urandom_range(0, 4)), m_err, m_rdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
